count_mod_n: RTL and testbench

Parametrised synchronous modulo-N up/down counter with a built-in clock-enable prescaler, a parallel load, and a terminal-count pulse. It supersedes the fixed 4-bit divided-clock counters used on the board designs. All logic runs on the single board clock; the prescaler produces an enable tick rather than a derived clock. Typical use is a slow visible count on LEDs or a seven-segment display, such as mod-12 at 1 Hz from a 100 MHz clock.

---
 rtl/count_mod_n_if.sv | 15 +
 rtl/count_mod_n.sv | 85 ++++++++
 tb/tb_count_mod_n.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/count_mod_n_if.sv
// Control and status bundle for count_mod_n: enable, direction, load strobe and value in; count and pulses out.
interface count_mod_n_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic             tick;
    logic             tc;

    modport master (output en, up, load, din, input  q, tick, tc);
    modport slave  (input  en, up, load, din, output q, tick, tc);
endinterface

// File: rtl/count_mod_n.sv
// Modulo-N up/down counter advanced by a clock-enable prescaler, with clamped parallel load
// and registered tick / terminal-count pulses. Single clock domain, no derived clocks.
module count_mod_n #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MODULUS   = 12,
    parameter int unsigned DIV_WIDTH = 27,
    parameter int unsigned DIV_TERM  = 99_999_999
) (
    input  logic          clk,
    input  logic          reset,
    count_mod_n_if.slave  bus
);

    localparam int unsigned EXT_WIDTH = WIDTH + 1;
    localparam logic [WIDTH-1:0]     Q_MAX    = WIDTH'(MODULUS - 1);
    localparam logic [EXT_WIDTH-1:0] MOD_EXT  = EXT_WIDTH'(MODULUS);
    localparam logic [DIV_WIDTH-1:0] PRE_TERM = DIV_WIDTH'(DIV_TERM);

    logic [WIDTH-1:0]     r_q;
    logic [DIV_WIDTH-1:0] r_pre;
    logic                 r_tick;
    logic                 r_tc;

    logic [WIDTH-1:0]     w_q_next;
    logic [DIV_WIDTH-1:0] w_pre_next;
    logic                 w_tick_next;
    logic                 w_tc_next;
    logic [WIDTH-1:0]     w_din_clamped;

    // Extended compare so MODULUS == 2**WIDTH never clamps a legal value.
    assign w_din_clamped = ({1'b0, bus.din} >= MOD_EXT) ? Q_MAX : bus.din;

    // Next state: load beats enable, enable beats hold; pulses default low.
    always_comb begin
        w_q_next    = r_q;
        w_pre_next  = r_pre;
        w_tick_next = 1'b0;
        w_tc_next   = 1'b0;
        if (bus.load) begin
            w_q_next   = w_din_clamped;
            w_pre_next = '0;
        end else if (bus.en) begin
            if (r_pre == PRE_TERM) begin
                w_pre_next  = '0;
                w_tick_next = 1'b1;
                if (bus.up) begin
                    if (r_q == Q_MAX) begin
                        w_q_next  = '0;
                        w_tc_next = 1'b1;
                    end else begin
                        w_q_next = r_q + WIDTH'(1);
                    end
                end else begin
                    if (r_q == '0) begin
                        w_q_next  = Q_MAX;
                        w_tc_next = 1'b1;
                    end else begin
                        w_q_next = r_q - WIDTH'(1);
                    end
                end
            end else begin
                w_pre_next = r_pre + DIV_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q    <= '0;
            r_pre  <= '0;
            r_tick <= 1'b0;
            r_tc   <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_pre  <= w_pre_next;
            r_tick <= w_tick_next;
            r_tc   <= w_tc_next;
        end
    end

    assign bus.q    = r_q;
    assign bus.tick = r_tick;
    assign bus.tc   = r_tc;

endmodule

// File: tb/tb_count_mod_n.sv
// Bench for count_mod_n (mod-12, prescale by 4): directed scenarios plus a randomized run
// against an arithmetic reference model.
module tb_count_mod_n;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned MOD   = 12;
    localparam int unsigned DT    = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    count_mod_n_if #(.WIDTH(WIDTH)) bus ();

    count_mod_n #(
        .WIDTH(WIDTH), .MODULUS(MOD), .DIV_WIDTH(27), .DIV_TERM(DT)
    ) u_dut (
        .clk(clk), .reset(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: count kept as an integer, stepped with modulo arithmetic.
    int m_q;
    int m_p;
    bit m_tick;
    bit m_tc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= 0; m_p <= 0; m_tick <= 1'b0; m_tc <= 1'b0;
        end else if (bus.load) begin
            m_q <= (int'(bus.din) >= int'(MOD)) ? int'(MOD) - 1 : int'(bus.din);
            m_p <= 0; m_tick <= 1'b0; m_tc <= 1'b0;
        end else if (bus.en && m_p == int'(DT)) begin
            m_p    <= 0;
            m_tick <= 1'b1;
            m_q    <= bus.up ? (m_q + 1) % int'(MOD) : (m_q + int'(MOD) - 1) % int'(MOD);
            m_tc   <= bus.up ? (m_q == int'(MOD) - 1) : (m_q == 0);
        end else begin
            if (bus.en) m_p <= m_p + 1;
            m_tick <= 1'b0; m_tc <= 1'b0;
        end
    end

    task automatic drive(input logic en, input logic up, input logic load, input logic [WIDTH-1:0] din);
        bus.en = en; bus.up = up; bus.load = load; bus.din = din;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 1'b0, '0);
        rst_n = 1'b0;
        #12;
        checks++; if (bus.q !== 4'd0) begin errors++; $display("FAIL reset_q got %0d want 0", bus.q); end
        checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", bus.tick); end
        checks++; if (bus.tc !== 1'b0) begin errors++; $display("FAIL reset_tc got %b want 0", bus.tc); end
    endtask

    task automatic test_run();
        logic [WIDTH-1:0] exp_q;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, '0);
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            exp_q = (e < 4) ? 4'd0 : (e < 8) ? 4'd1 : 4'd2;
            checks++; if (bus.q !== exp_q) begin errors++; $display("FAIL run_q edge %0d got %0d want %0d", e, bus.q, exp_q); end
            checks++; if (bus.tick !== (e == 4 || e == 8)) begin errors++; $display("FAIL run_tick edge %0d got %b", e, bus.tick); end
        end
    endtask

    task automatic test_up_wrap();
        logic [WIDTH-1:0] exp_q;
        drive(1'b1, 1'b1, 1'b1, 4'd10);
        @(negedge clk);
        checks++; if (bus.q !== 4'd10) begin errors++; $display("FAIL upwrap_load got %0d want 10", bus.q); end
        drive(1'b1, 1'b1, 1'b0, '0);
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            exp_q = (e < 4) ? 4'd10 : (e < 8) ? 4'd11 : 4'd0;
            checks++; if (bus.q !== exp_q) begin errors++; $display("FAIL upwrap_q edge %0d got %0d want %0d", e, bus.q, exp_q); end
            checks++; if (bus.tc !== (e == 8)) begin errors++; $display("FAIL upwrap_tc edge %0d got %b", e, bus.tc); end
        end
    endtask

    task automatic test_down_wrap();
        logic [WIDTH-1:0] exp_q;
        drive(1'b1, 1'b0, 1'b1, 4'd1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            exp_q = (e < 4) ? 4'd1 : (e < 8) ? 4'd0 : (e < 12) ? 4'd11 : 4'd10;
            checks++; if (bus.q !== exp_q) begin errors++; $display("FAIL downwrap_q edge %0d got %0d want %0d", e, bus.q, exp_q); end
            checks++; if (bus.tc !== (e == 8)) begin errors++; $display("FAIL downwrap_tc edge %0d got %b", e, bus.tc); end
        end
    endtask

    task automatic test_load();
        drive(1'b1, 1'b1, 1'b1, 4'd0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, '0);
        repeat (2) @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 4'd7);
        @(negedge clk);
        checks++; if (bus.q !== 4'd7) begin errors++; $display("FAIL load7 got %0d want 7", bus.q); end
        drive(1'b1, 1'b1, 1'b0, '0);
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            checks++;
            if (bus.q !== ((e < 4) ? 4'd7 : 4'd8)) begin
                errors++; $display("FAIL load_next edge %0d got %0d want %0d", e, bus.q, (e < 4) ? 7 : 8);
            end
        end
        drive(1'b1, 1'b1, 1'b1, 4'd14);
        @(negedge clk);
        checks++; if (bus.q !== 4'd11) begin errors++; $display("FAIL load_clamp got %0d want 11", bus.q); end
        drive(1'b1, 1'b1, 1'b0, '0);
        repeat (3) @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 4'd5);
        @(negedge clk);
        checks++; if (bus.q !== 4'd5) begin errors++; $display("FAIL load_vs_tick_q got %0d want 5", bus.q); end
        checks++; if (bus.tc !== 1'b0 || bus.tick !== 1'b0) begin
            errors++; $display("FAIL load_vs_tick_pulse got tick=%b tc=%b want 0 0", bus.tick, bus.tc);
        end
    endtask

    task automatic test_enable_hold();
        drive(1'b1, 1'b1, 1'b1, 4'd4);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, '0);
        repeat (2) @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, '0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++; if (bus.q !== 4'd4 || bus.tick !== 1'b0) begin
                errors++; $display("FAIL hold cycle %0d got q=%0d tick=%b want 4 0", c, bus.q, bus.tick);
            end
        end
        drive(1'b1, 1'b1, 1'b0, '0);
        @(negedge clk);
        checks++; if (bus.q !== 4'd4) begin errors++; $display("FAIL resume_e1 got %0d want 4", bus.q); end
        @(negedge clk);
        checks++; if (bus.q !== 4'd5 || bus.tick !== 1'b1) begin
            errors++; $display("FAIL resume_e2 got q=%0d tick=%b want 5 1", bus.q, bus.tick);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 1'b1, 4'd9);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, '0);
        repeat (2) @(negedge clk);
        checks++; if (bus.q !== 4'd9) begin errors++; $display("FAIL areset_pre got %0d want 9", bus.q); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.q !== 4'd0) begin errors++; $display("FAIL areset_q got %0d want 0", bus.q); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            checks++;
            if (bus.q !== ((e < 4) ? 4'd0 : 4'd1)) begin
                errors++; $display("FAIL areset_restart edge %0d got %0d want %0d", e, bus.q, (e < 4) ? 0 : 1);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            drive(($urandom_range(0, 9) != 0), 1'($urandom), ($urandom_range(0, 19) == 0), 4'($urandom));
            @(negedge clk);
            checks++;
            if (bus.q !== 4'(m_q) || bus.tick !== m_tick || bus.tc !== m_tc) begin
                errors++;
                $display("FAIL random cycle %0d got q=%0d tick=%b tc=%b want q=%0d tick=%b tc=%b",
                         c, bus.q, bus.tick, bus.tc, m_q, m_tick, m_tc);
            end
            checks++; if (int'(bus.q) >= int'(MOD)) begin errors++; $display("FAIL random_range cycle %0d got %0d want <12", c, bus.q); end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_run();
        test_up_wrap();
        test_down_wrap();
        test_load();
        test_enable_hold();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
